// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: direct-mapped BTB with 2-bit counters; EX-stage resolution drives flush/redirect and table update.
// Optional performance counters (br_cnt_o, miss_cnt_o) are enabled by defining BP_PERF_CNT_EN.
module branch_predict_ctrl #(
  parameter int ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  input  logic        ex_valid_i,
  input  logic        ex_br_i,
  input  logic        ex_jmp_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_pc_i,
  output logic        flush_o,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] br_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  output logic [31:0] redirect_pc_o
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;
  logic          r_valid  [ENTRIES];
  logic [TW-1:0] r_tag    [ENTRIES];
  logic [31:0]   r_target [ENTRIES];
  logic [1:0]    r_ctr    [ENTRIES];
  logic          r_jmp    [ENTRIES];
  logic [IDX-1:0] w_if_idx, w_ex_idx;
  logic           w_if_hit, w_ex_hit, w_cf, w_upd, w_unused;
  logic [31:0]    w_actual;
  logic [1:0]     w_ctr, w_ctr_nxt;
  always_comb begin
    w_if_idx      = if_pc_i[IDX+1:2];
    w_ex_idx      = ex_pc_i[IDX+1:2];
    w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == if_pc_i[31:IDX+2]);
    w_ex_hit      = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == ex_pc_i[31:IDX+2]);
    pred_taken_o  = w_if_hit & (r_ctr[w_if_idx][1] | r_jmp[w_if_idx]);
    pred_pc_o     = pred_taken_o ? r_target[w_if_idx] : if_pc_i + 32'd4;
    w_cf          = ex_br_i | ex_jmp_i;
    w_actual      = (ex_taken_i & w_cf) ? ex_target_i : ex_pc_i + 32'd4;
    flush_o       = ~rst_i & ex_valid_i & ~stall_i & (w_actual != ex_pred_pc_i);
    redirect_pc_o = flush_o ? w_actual : 32'd0;
    w_upd         = ~rst_i & ex_valid_i & ~stall_i;
    w_ctr         = r_ctr[w_ex_idx];
    w_ctr_nxt     = (ex_jmp_i | r_jmp[w_ex_idx]) ? 2'b11 :
                    ex_taken_i ? ((w_ctr == 2'b11) ? w_ctr : w_ctr + 2'd1) :
                                 ((w_ctr == 2'b00) ? w_ctr : w_ctr - 2'd1);
    w_unused      = ex_pred_taken_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
        r_ctr[i]    <= 2'b01;
        r_jmp[i]    <= 1'b0;
      end
    end else if (w_upd) begin
      if (w_cf && w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_nxt;
        if (ex_taken_i) r_target[w_ex_idx] <= ex_target_i;
      end else if (w_cf && ex_taken_i) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= ex_pc_i[31:IDX+2];
        r_target[w_ex_idx] <= ex_target_i;
        r_ctr[w_ex_idx]    <= ex_jmp_i ? 2'b11 : 2'b10;
        r_jmp[w_ex_idx]    <= ex_jmp_i;
      end else if (!w_cf && w_ex_hit) begin
        // a non-branch matching an entry means stale/aliased contents
        r_valid[w_ex_idx] <= 1'b0;
      end
    end
  end
`ifdef BP_PERF_CNT_EN
  logic [31:0] r_br_cnt, r_miss_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_upd && w_cf && !(&r_br_cnt)) r_br_cnt <= r_br_cnt + 32'd1;
      if (flush_o && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  assign br_cnt_o   = r_br_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif
endmodule
